// File: rtl/frame_color_scan_if.sv
// Bus between the frame colour scanner and its environment: scan control,
// frame buffer read port and classification results.
interface frame_color_scan_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] cnt_red;
    logic [AW-1:0] cnt_green;
    logic [AW-1:0] cnt_blue;

    modport slave (
        input  start, mem_data,
        output mem_addr, busy, done, color, cnt_red, cnt_green, cnt_blue
    );

    modport master (
        output start, mem_data,
        input  mem_addr, busy, done, color, cnt_red, cnt_green, cnt_blue
    );
endinterface

// File: rtl/frame_color_scan.sv
// Sweeps every RGB332 pixel of the frame buffer once per start request, counts
// red/green/blue-dominant pixels and registers the winning colour.
module frame_color_scan #(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int NPIX    = 19200,
    parameter int MIN_PIX = 200
) (
    input  logic                clk,
    input  logic                rst,
    frame_color_scan_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW-1:0] MIN_CNT   = AW'(MIN_PIX);
    localparam logic [AW-1:0] CNT_ONE   = AW'(1);

    state_t        state, state_nxt;
    logic          vld_p1;
    logic [1:0]    cls_p1;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] cnt_red, cnt_green, cnt_blue;
    logic [1:0]    color;
    logic          busy, done;

    // 00 = not counted, 01 red, 10 green, 11 blue; the three classes are disjoint.
    function automatic logic [1:0] classify(input logic [DW-1:0] pix);
        logic [2:0] r, g;
        logic [1:0] b;
        r = pix[7:5];
        g = pix[4:2];
        b = pix[1:0];
        classify = 2'b00;
        if (r >= 3'd5 && g <= 3'd2 && b <= 2'd1)
            classify = 2'b01;
        else if (g >= 3'd5 && r <= 3'd2 && b <= 2'd1)
            classify = 2'b10;
        else if (b == 2'd3 && r <= 3'd2 && g <= 3'd2)
            classify = 2'b11;
    endfunction

    // >= comparisons give ties to red first, then green.
    function automatic logic [1:0] decide_color(input logic [AW-1:0] r,
                                                input logic [AW-1:0] g,
                                                input logic [AW-1:0] b);
        logic [1:0]    win;
        logic [AW-1:0] win_cnt;
        if (r >= g && r >= b) begin
            win     = 2'b01;
            win_cnt = r;
        end else if (g >= b) begin
            win     = 2'b10;
            win_cnt = g;
        end else begin
            win     = 2'b11;
            win_cnt = b;
        end
        decide_color = (win_cnt >= MIN_CNT) ? win : 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (mem_addr == LAST_ADDR)
                    state_nxt = DRAIN;
            end
            DRAIN:  state_nxt = DECIDE;
            DECIDE: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: RAM data for the address issued last cycle is classified here.
    assign cls_p1 = classify(bus.mem_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr  <= '0;
            vld_p1    <= 1'b0;
            cnt_red   <= '0;
            cnt_green <= '0;
            cnt_blue  <= '0;
            color     <= 2'b00;
        end else begin
            vld_p1 <= (state == SCAN);
            if (vld_p1) begin
                case (cls_p1)
                    2'b01:   cnt_red   <= cnt_red + CNT_ONE;
                    2'b10:   cnt_green <= cnt_green + CNT_ONE;
                    2'b11:   cnt_blue  <= cnt_blue + CNT_ONE;
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    mem_addr <= '0;
                    if (bus.start) begin
                        cnt_red   <= '0;
                        cnt_green <= '0;
                        cnt_blue  <= '0;
                        color     <= 2'b00;
                    end
                end
                SCAN: begin
                    if (mem_addr != LAST_ADDR)
                        mem_addr <= mem_addr + CNT_ONE;
                end
                DECIDE: color <= decide_color(cnt_red, cnt_green, cnt_blue);
                DONE:   mem_addr <= '0;
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.color     = color;
    assign bus.cnt_red   = cnt_red;
    assign bus.cnt_green = cnt_green;
    assign bus.cnt_blue  = cnt_blue;
endmodule

// File: tb/tb_frame_color_scan.sv
// Bench for frame_color_scan: a small 16-pixel instance for timing/edge cases
// and a default-size instance fed a random frame.
module tb_frame_color_scan;
    localparam int AW = 15;

    typedef struct {
        logic [1:0]    color;
        logic [AW-1:0] r;
        logic [AW-1:0] g;
        logic [AW-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic [7:0] img [0:19199];

    always #5 clk = ~clk;

    frame_color_scan_if #(.AW(AW), .DW(8)) s_if ();
    frame_color_scan_if #(.AW(AW), .DW(8)) b_if ();

    frame_color_scan #(.AW(AW), .DW(8), .NPIX(16), .MIN_PIX(4)) dut_s (
        .clk(clk), .rst(rst), .bus(s_if.slave)
    );
    frame_color_scan #(.AW(AW), .DW(8), .NPIX(19200), .MIN_PIX(200)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    // Registered frame buffers, one cycle read latency.
    always_ff @(posedge clk) s_if.mem_data <= img[s_if.mem_addr];
    always_ff @(posedge clk) b_if.mem_data <= img[b_if.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t ref_result(input int n, input int min_pix);
        exp_t e;
        int nr, ng, nb, best, r, g, b;
        logic [1:0] col;
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < n; i++) begin
            r = int'(img[i] >> 5);
            g = int'((img[i] >> 2) & 8'h07);
            b = int'(img[i] & 8'h03);
            if (b == 3 && r < 3 && g < 3) nb++;
            else if (r > 4 && g < 3 && b < 2) nr++;
            else if (g > 4 && r < 3 && b < 2) ng++;
        end
        col = 2'b01; best = nr;
        if (ng > best) begin col = 2'b10; best = ng; end
        if (nb > best) begin col = 2'b11; best = nb; end
        if (best < min_pix) col = 2'b00;
        e.color = col;
        e.r = AW'(nr);
        e.g = AW'(ng);
        e.b = AW'(nb);
        return e;
    endfunction

    task automatic fill(input logic [7:0] a, input int na,
                        input logic [7:0] b, input int nb, input logic [7:0] c);
        for (int i = 0; i < 16; i++)
            img[i] = (i < na) ? a : ((i < na + nb) ? b : c);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_if.start = 1'b1;
        b_if.start = 1'b0;
        tick();
        tick();
        checks += 6;
        if (s_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", s_if.busy); end
        if (s_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", s_if.done); end
        if (s_if.color !== 2'b00) begin errors++; $display("FAIL reset_color: got %b expected 00", s_if.color); end
        if (s_if.mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", s_if.mem_addr); end
        if (s_if.cnt_red !== '0 || s_if.cnt_green !== '0) begin
            errors++; $display("FAIL reset_cnt_rg: got %0d/%0d expected 0/0", s_if.cnt_red, s_if.cnt_green);
        end
        if (s_if.cnt_blue !== '0) begin errors++; $display("FAIL reset_cnt_b: got %0d expected 0", s_if.cnt_blue); end
        s_if.start = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    // One start pulse at relative cycle 0; optional extra pulses in SCAN (5) and DECIDE (18).
    task automatic scan_small(input bit poke, input string name);
        exp_t e;
        int   ndone = 0;
        exp_q.push_back(ref_result(16, 4));
        s_if.start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            s_if.start = poke && (c == 5 || c == 18);
            if (c <= 16) begin
                checks++;
                if (s_if.mem_addr !== AW'(c - 1)) begin
                    errors++; $display("FAIL %s_addr c%0d: got %0d expected %0d", name, c, s_if.mem_addr, c - 1);
                end
            end
            if (c == 1 || c == 20) begin
                checks++;
                if (s_if.busy !== (c == 1)) begin
                    errors++; $display("FAIL %s_busy c%0d: got %b expected %b", name, c, s_if.busy, c == 1);
                end
            end
            if (s_if.done === 1'b1) begin
                ndone++;
                checks++;
                if (c != 19) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 19", name, c); end
                if (ndone == 1) begin
                    checks += 4;
                    if (exp_q.size() == 0) begin
                        errors += 4; $display("FAIL %s_queue: got empty expected entry", name);
                    end else begin
                        e = exp_q.pop_front();
                        if (s_if.color !== e.color) begin errors++; $display("FAIL %s_color: got %b expected %b", name, s_if.color, e.color); end
                        if (s_if.cnt_red !== e.r) begin errors++; $display("FAIL %s_red: got %0d expected %0d", name, s_if.cnt_red, e.r); end
                        if (s_if.cnt_green !== e.g) begin errors++; $display("FAIL %s_green: got %0d expected %0d", name, s_if.cnt_green, e.g); end
                        if (s_if.cnt_blue !== e.b) begin errors++; $display("FAIL %s_blue: got %0d expected %0d", name, s_if.cnt_blue, e.b); end
                    end
                end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL %s_ndone: got %0d expected 1", name, ndone); end
        checks++;
        if (s_if.color !== e.color) begin errors++; $display("FAIL %s_color_hold: got %b expected %b", name, s_if.color, e.color); end
    endtask

    task automatic test_basic();
        fill(8'hE0, 8, 8'h1C, 4, 8'h00);
        scan_small(1'b0, "basic");
    endtask

    task automatic test_tie_threshold();
        fill(8'h1C, 5, 8'h03, 5, 8'h00);
        scan_small(1'b0, "tie");
        fill(8'hFF, 16, 8'hFF, 0, 8'hFF);
        scan_small(1'b0, "allff");
        fill(8'h03, 3, 8'h00, 13, 8'h00);
        scan_small(1'b0, "below_min");
    endtask

    task automatic test_ignore_start();
        for (int i = 0; i < 16; i++) img[i] = (i % 3 == 0) ? 8'h03 : ((i % 3 == 1) ? 8'hA1 : 8'h54);
        scan_small(1'b1, "ignore");
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        fill(8'hE0, 8, 8'h1C, 4, 8'h00);
        s_if.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            s_if.start = 1'b0;
        end
        checks++;
        if (s_if.cnt_red === '0) begin errors++; $display("FAIL midrst_live_cnt: got %0d expected nonzero", s_if.cnt_red); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks += 4;
        if (s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0/0", s_if.busy, s_if.done);
        end
        if (s_if.mem_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", s_if.mem_addr); end
        if (s_if.color !== 2'b00) begin errors++; $display("FAIL midrst_color: got %b expected 00", s_if.color); end
        if (s_if.cnt_red !== '0 || s_if.cnt_green !== '0 || s_if.cnt_blue !== '0) begin
            errors++; $display("FAIL midrst_cnt: got %0d/%0d/%0d expected 0/0/0", s_if.cnt_red, s_if.cnt_green, s_if.cnt_blue);
        end
        for (int c = 0; c < 25; c++) begin
            tick();
            if (s_if.done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        scan_small(1'b0, "after_rst");
    endtask

    // start held high: second scan is accepted in the IDLE cycle right after DONE.
    task automatic test_back_to_back();
        exp_t e;
        int   ndone = 0;
        for (int i = 0; i < 16; i++) img[i] = (i < 6) ? 8'h02 : 8'h1D;
        e = ref_result(16, 4);
        exp_q.push_back(e);
        exp_q.push_back(e);
        s_if.start = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            tick();
            if (c == 21) s_if.start = 1'b0;
            if (s_if.done === 1'b1) begin
                ndone++;
                checks += 5;
                if (c != 19 * ndone + (ndone - 1)) begin
                    errors++; $display("FAIL b2b_done_cycle: got %0d expected %0d", c, 19 * ndone + (ndone - 1));
                end
                if (exp_q.size() == 0) begin
                    errors += 4; $display("FAIL b2b_queue: got empty expected entry");
                end else begin
                    e = exp_q.pop_front();
                    if (s_if.color !== e.color) begin errors++; $display("FAIL b2b_color: got %b expected %b", s_if.color, e.color); end
                    if (s_if.cnt_red !== e.r) begin errors++; $display("FAIL b2b_red: got %0d expected %0d", s_if.cnt_red, e.r); end
                    if (s_if.cnt_green !== e.g) begin errors++; $display("FAIL b2b_green: got %0d expected %0d", s_if.cnt_green, e.g); end
                    if (s_if.cnt_blue !== e.b) begin errors++; $display("FAIL b2b_blue: got %0d expected %0d", s_if.cnt_blue, e.b); end
                end
            end
        end
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL b2b_ndone: got %0d expected 2", ndone); end
    endtask

    task automatic test_random_full();
        exp_t e;
        int   max_addr = 0;
        int   done_c = -1;
        for (int i = 0; i < 19200; i++) img[i] = 8'($urandom);
        exp_q.push_back(ref_result(19200, 200));
        b_if.start = 1'b1;
        for (int c = 1; c <= 19300 && done_c < 0; c++) begin
            tick();
            b_if.start = 1'b0;
            if (int'(b_if.mem_addr) > max_addr) max_addr = int'(b_if.mem_addr);
            if (b_if.done === 1'b1) done_c = c;
        end
        checks += 6;
        if (max_addr != 19199) begin errors++; $display("FAIL rand_max_addr: got %0d expected 19199", max_addr); end
        if (done_c != 19203) begin errors++; $display("FAIL rand_done_cycle: got %0d expected 19203", done_c); end
        if (exp_q.size() == 0 || done_c < 0) begin
            errors += 4; $display("FAIL rand_result: got no result expected one");
        end else begin
            e = exp_q.pop_front();
            if (b_if.color !== e.color) begin errors++; $display("FAIL rand_color: got %b expected %b", b_if.color, e.color); end
            if (b_if.cnt_red !== e.r) begin errors++; $display("FAIL rand_red: got %0d expected %0d", b_if.cnt_red, e.r); end
            if (b_if.cnt_green !== e.g) begin errors++; $display("FAIL rand_green: got %0d expected %0d", b_if.cnt_green, e.g); end
            if (b_if.cnt_blue !== e.b) begin errors++; $display("FAIL rand_blue: got %0d expected %0d", b_if.cnt_blue, e.b); end
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) img[i] = 8'h00;
        test_reset();
        test_basic();
        test_tie_threshold();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random_full();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_empty: got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
